beat_window_counter: RTL and testbench

Parametrised successor of the fixed 60 s window timer in the heart-rate path. Runs on the system clock and uses a 1 Hz tick strobe. Counts a configurable window of seconds and counts beat edges inside that window. At window close it publishes a scaled BPM value, in either one-shot or periodic (rolling re-arm) mode. Sits between the beat detector and the BPM display/formatting logic.

---
 rtl/beat_window_counter.sv | 161 ++++++++++++++++
 tb/tb_beat_window_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_window_counter.sv
// beat_window_counter: counts beat rising edges over a window of WINDOW_S
// seconds, driven by a 1 Hz sec_tick strobe. At window close it publishes
// bpm = min(beats * (60 / WINDOW_S), 2^BPM_W-1). It runs one-shot or
// periodic (rolling re-arm).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | disabled; elapsed/beat count held at zero, bpm retained
// ST_COUNT | window open; counting beats and seconds (busy)
// ST_DONE  | one-shot window closed; counters frozen until en_cont drops
//
// WINDOW_S must be in 1..60 and divide 60 exactly, and 2^SEC_W > WINDOW_S.
module beat_window_counter #(
  parameter int WINDOW_S = 60,
  parameter int SEC_W    = 6,
  parameter int BEAT_W   = 8,
  parameter int BPM_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_cont_i,
  input  logic              sec_tick_i,
  input  logic              beat_i,
  input  logic              mode_cont_i,
  output logic [SEC_W-1:0]  elapsed_o,
  output logic [BEAT_W-1:0] beat_cnt_o,
  output logic [BPM_W-1:0]  bpm_o,
  output logic              bpm_valid_o,
  output logic              bpm_sat_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int MULT = 60 / WINDOW_S;
  // Product width: wide enough for beat count times a 6-bit scale factor,
  // and always wider than the bpm output so the clip compare is exact.
  localparam int PW = ((BEAT_W + 7) > (BPM_W + 1)) ? (BEAT_W + 7) : (BPM_W + 1);
  localparam logic [PW-1:0]    BPM_MAX  = {{(PW-BPM_W){1'b0}}, {BPM_W{1'b1}}};
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(WINDOW_S - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SEC_W-1:0]  elapsed_q, elapsed_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BPM_W-1:0]  bpm_q, bpm_d;
  logic              bpm_valid_q, bpm_valid_d;
  logic              bpm_sat_q, bpm_sat_d;
  logic              sat_q, sat_d;
  logic              beat_q;

  logic              beat_rise;
  logic              cnt_max;
  logic [BEAT_W-1:0] cnt_inc;
  logic              sat_inc;
  logic [PW-1:0]     prod;
  logic              clip;

  assign beat_rise = beat_i & ~beat_q;
  assign cnt_max   = &beat_cnt_q;
  assign cnt_inc   = (beat_rise && !cnt_max) ? beat_cnt_q + BEAT_W'(1) : beat_cnt_q;
  assign sat_inc   = sat_q | (beat_rise & cnt_max);
  assign prod      = {{(PW-BEAT_W){1'b0}}, cnt_inc} * PW'(MULT);
  assign clip      = prod > BPM_MAX;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      elapsed_q   <= '0;
      beat_cnt_q  <= '0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
      bpm_sat_q   <= 1'b0;
      sat_q       <= 1'b0;
      beat_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      beat_cnt_q  <= beat_cnt_d;
      bpm_q       <= bpm_d;
      bpm_valid_q <= bpm_valid_d;
      bpm_sat_q   <= bpm_sat_d;
      sat_q       <= sat_d;
      beat_q      <= beat_i;
    end
  end

  // Next-state and datapath update; en_cont low always returns to idle.
  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    beat_cnt_d  = beat_cnt_q;
    bpm_d       = bpm_q;
    bpm_valid_d = 1'b0;
    bpm_sat_d   = bpm_sat_q;
    sat_d       = sat_q;

    unique case (state_q)
      ST_IDLE: begin
        elapsed_d  = '0;
        beat_cnt_d = '0;
        sat_d      = 1'b0;
        if (en_cont_i) state_d = ST_COUNT;
      end

      ST_COUNT: begin
        if (!en_cont_i) begin
          state_d    = ST_IDLE;
          elapsed_d  = '0;
          beat_cnt_d = '0;
          sat_d      = 1'b0;
        end else if (sec_tick_i && (elapsed_q == LAST_SEC)) begin
          // A beat edge on the closing tick belongs to this window.
          bpm_d       = clip ? BPM_MAX[BPM_W-1:0] : prod[BPM_W-1:0];
          bpm_sat_d   = sat_inc | clip;
          bpm_valid_d = 1'b1;
          if (mode_cont_i) begin
            elapsed_d  = '0;
            beat_cnt_d = '0;
            sat_d      = 1'b0;
          end else begin
            state_d    = ST_DONE;
            beat_cnt_d = cnt_inc;
            sat_d      = sat_inc;
          end
        end else begin
          beat_cnt_d = cnt_inc;
          sat_d      = sat_inc;
          if (sec_tick_i) elapsed_d = elapsed_q + SEC_W'(1);
        end
      end

      ST_DONE: begin
        if (!en_cont_i) begin
          state_d    = ST_IDLE;
          elapsed_d  = '0;
          beat_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign elapsed_o   = elapsed_q;
  assign beat_cnt_o  = beat_cnt_q;
  assign bpm_o       = bpm_q;
  assign bpm_valid_o = bpm_valid_q;
  assign bpm_sat_o   = bpm_sat_q;
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_COUNT);

endmodule

// File: tb/tb_beat_window_counter.sv
// Directed bench for beat_window_counter. Three instances:
//   u0: WINDOW_S=60, BEAT_W=8   u1: WINDOW_S=15, BEAT_W=8   u2: WINDOW_S=60, BEAT_W=4
module tb_beat_window_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, en, tick, beat, mode;

  logic [5:0] el0, el1, el2;
  logic [7:0] bc0, bc1;
  logic [3:0] bc2;
  logic [9:0] bpm0, bpm1, bpm2;
  logic       v0, v1, v2, s0, s1, s2, d0, d1, d2, b0, b1, b2;

  int checks = 0;
  int failures = 0;

  beat_window_counter #(.WINDOW_S(60), .SEC_W(6), .BEAT_W(8), .BPM_W(10)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .en_cont_i(en[0]), .sec_tick_i(tick[0]),
    .beat_i(beat[0]), .mode_cont_i(mode[0]), .elapsed_o(el0), .beat_cnt_o(bc0),
    .bpm_o(bpm0), .bpm_valid_o(v0), .bpm_sat_o(s0), .done_o(d0), .busy_o(b0));

  beat_window_counter #(.WINDOW_S(15), .SEC_W(6), .BEAT_W(8), .BPM_W(10)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .en_cont_i(en[1]), .sec_tick_i(tick[1]),
    .beat_i(beat[1]), .mode_cont_i(mode[1]), .elapsed_o(el1), .beat_cnt_o(bc1),
    .bpm_o(bpm1), .bpm_valid_o(v1), .bpm_sat_o(s1), .done_o(d1), .busy_o(b1));

  beat_window_counter #(.WINDOW_S(60), .SEC_W(6), .BEAT_W(4), .BPM_W(10)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .en_cont_i(en[2]), .sec_tick_i(tick[2]),
    .beat_i(beat[2]), .mode_cont_i(mode[2]), .elapsed_o(el2), .beat_cnt_o(bc2),
    .bpm_o(bpm2), .bpm_valid_o(v2), .bpm_sat_o(s2), .done_o(d2), .busy_o(b2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; return 1 time unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input int k);
    tick[k] = 1'b1;
    step(1);
    tick[k] = 1'b0;
  endtask

  task automatic do_beat(input int k);
    beat[k] = 1'b1;
    step(1);
    beat[k] = 1'b0;
    step(1);
  endtask

  initial begin
    rst = '1; en = '0; tick = '0; beat = '0; mode = '0;
    step(2);
    rst = '0;
    step(1);

    // Reset state
    check("rst_elapsed", el0, 0);
    check("rst_beat_cnt", bc0, 0);
    check("rst_bpm", bpm0, 0);
    check("rst_valid", v0, 0);
    check("rst_done", d0, 0);
    check("rst_busy", b0, 0);

    // 1: one-shot, 72 beats over 60 s
    en[0] = 1'b1;
    step(1);
    check("t1_busy", b0, 1);
    for (int i = 0; i < 59; i++) begin
      do_beat(0);
      if (i < 13) do_beat(0);
      do_tick(0);
    end
    check("t1_elapsed_pre", el0, 59);
    check("t1_cnt_pre", bc0, 72);
    check("t1_valid_pre", v0, 0);
    tick[0] = 1'b1;
    step(1);
    tick[0] = 1'b0;
    check("t1_valid", v0, 1);
    check("t1_bpm", bpm0, 72);
    check("t1_done", d0, 1);
    check("t1_busy_done", b0, 0);
    check("t1_elapsed", el0, 59);
    step(1);
    check("t1_valid_1cyc", v0, 0);
    do_beat(0);
    do_tick(0);
    check("t1_cnt_frozen", bc0, 72);
    check("t1_elapsed_frozen", el0, 59);

    // 4: abort mid-window keeps previous bpm
    en[0] = 1'b0;
    step(1);
    check("t4_idle_done", d0, 0);
    check("t4_idle_elapsed", el0, 0);
    en[0] = 1'b1;
    step(1);
    for (int i = 0; i < 30; i++) begin
      do_beat(0);
      if (i < 10) do_beat(0);
      do_tick(0);
    end
    check("t4_elapsed_pre", el0, 30);
    check("t4_cnt_pre", bc0, 40);
    en[0] = 1'b0;
    step(1);
    check("t4_elapsed", el0, 0);
    check("t4_cnt", bc0, 0);
    check("t4_busy", b0, 0);
    check("t4_valid", v0, 0);
    check("t4_bpm_kept", bpm0, 72);
    en[0] = 1'b1;
    step(1);
    check("t4_rearm_busy", b0, 1);
    check("t4_rearm_elapsed", el0, 0);

    // 3: periodic, beat edge coincident with closing tick
    mode[0] = 1'b1;
    for (int i = 0; i < 59; i++) begin
      do_beat(0);
      if (i < 10) do_beat(0);
      do_tick(0);
    end
    check("t3_cnt_pre", bc0, 69);
    beat[0] = 1'b1;
    tick[0] = 1'b1;
    step(1);
    beat[0] = 1'b0;
    tick[0] = 1'b0;
    check("t3_valid", v0, 1);
    check("t3_bpm", bpm0, 70);
    check("t3_cnt_clr", bc0, 0);
    check("t3_elapsed_clr", el0, 0);
    check("t3_busy", b0, 1);
    check("t3_done", d0, 0);
    step(1);
    check("t3_cnt_next", bc0, 0);

    // 6: reset coincident with tick and beat; held beat not counted
    do_beat(0);
    do_tick(0);
    check("t6_cnt_pre", bc0, 1);
    check("t6_elapsed_pre", el0, 1);
    rst[0] = 1'b1;
    tick[0] = 1'b1;
    beat[0] = 1'b1;
    step(1);
    rst[0] = 1'b0;
    tick[0] = 1'b0;
    check("t6_elapsed", el0, 0);
    check("t6_cnt", bc0, 0);
    check("t6_bpm", bpm0, 0);
    check("t6_valid", v0, 0);
    check("t6_sat", s0, 0);
    check("t6_busy", b0, 0);
    check("t6_done", d0, 0);
    step(1);
    check("t6_busy_after", b0, 1);
    step(2);
    check("t6_held_beat", bc0, 0);
    beat[0] = 1'b0;
    step(1);
    beat[0] = 1'b1;
    step(1);
    check("t6_new_rise", bc0, 1);
    beat[0] = 1'b0;

    // 2: WINDOW_S=15 periodic, 18 beats per window, 3 windows
    en[1] = 1'b1;
    mode[1] = 1'b1;
    step(1);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 14; i++) begin
        do_beat(1);
        if (i < 4) do_beat(1);
        do_tick(1);
      end
      check("t2_elapsed_pre", el1, 14);
      check("t2_cnt_pre", bc1, 18);
      tick[1] = 1'b1;
      step(1);
      tick[1] = 1'b0;
      check("t2_valid", v1, 1);
      check("t2_bpm", bpm1, 72);
      check("t2_elapsed_wrap", el1, 0);
      check("t2_cnt_clr", bc1, 0);
      check("t2_done", d1, 0);
      step(1);
      check("t2_valid_1cyc", v1, 0);
    end

    // en_cont low on the closing tick wins
    for (int i = 0; i < 14; i++) begin
      do_beat(1);
      do_tick(1);
    end
    en[1] = 1'b0;
    tick[1] = 1'b1;
    step(1);
    tick[1] = 1'b0;
    check("abort_close_valid", v1, 0);
    check("abort_close_bpm", bpm1, 72);
    check("abort_close_busy", b1, 0);
    check("abort_close_elapsed", el1, 0);

    // 5: BEAT_W=4 saturation, then a clean window
    en[2] = 1'b1;
    step(1);
    for (int i = 0; i < 20; i++) do_beat(2);
    check("t5_cnt_sat", bc2, 15);
    for (int i = 0; i < 60; i++) do_tick(2);
    check("t5_valid", v2, 1);
    check("t5_bpm", bpm2, 15);
    check("t5_sat", s2, 1);
    check("t5_done", d2, 1);
    en[2] = 1'b0;
    step(1);
    check("t5_sat_kept_idle", s2, 1);
    en[2] = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) do_beat(2);
    for (int i = 0; i < 60; i++) do_tick(2);
    check("t5b_valid", v2, 1);
    check("t5b_bpm", bpm2, 10);
    check("t5b_sat", s2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
